// File: rtl/imem_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_prog_loader
// Description : Fills instruction memory from a framed byte stream
//               (length, N instruction bytes, checksum) and holds the core in
//               reset until a load completes with a good checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_prog_loader #(
    parameter int           ADDR_W   = 5,
    parameter bit           PAD_EN   = 1'b1,
    parameter logic [7:0]   PAD_WORD = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int         c_DEPTH_I = 1 << ADDR_W;
    localparam logic [8:0] c_DEPTH   = 9'(c_DEPTH_I);
    localparam logic [8:0] c_LAST    = 9'(c_DEPTH_I - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_PAD  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [7:0]        r_len;
    logic [8:0]        r_cnt;
    logic [7:0]        r_sum;
    logic              r_dwe;
    logic [ADDR_W-1:0] r_daddr;
    logic [7:0]        r_ddata;
    logic              w_xfer;
    logic              w_len_bad;

    assign w_xfer    = in_valid & in_ready;
    assign w_len_bad = (in_data == 8'd0) || ({1'b0, in_data} > c_DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_next = S_LEN;
            end
            S_LEN: begin
                if (w_xfer) w_next = w_len_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                if (w_xfer && ((r_cnt + 9'd1) == {1'b0, r_len})) w_next = S_CSUM;
            end
            S_CSUM: begin
                if (w_xfer) begin
                    if (in_data != r_sum)
                        w_next = S_ERR;
                    else if (PAD_EN && ({1'b0, r_len} < c_DEPTH))
                        w_next = S_PAD;
                    else
                        w_next = S_DONE;
                end
            end
            S_PAD: begin
                if (r_cnt == c_LAST) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Data writes are registered one cycle behind the accepted byte; pad
    // writes are driven combinationally from the PAD state below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len   <= 8'd0;
            r_cnt   <= 9'd0;
            r_sum   <= 8'd0;
            r_dwe   <= 1'b0;
            r_daddr <= '0;
            r_ddata <= 8'd0;
        end else begin
            r_dwe <= 1'b0;
            case (r_state)
                S_LEN: begin
                    if (w_xfer && !w_len_bad) begin
                        r_len <= in_data;
                        r_cnt <= 9'd0;
                        r_sum <= 8'd0;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_dwe   <= 1'b1;
                        r_daddr <= r_cnt[ADDR_W-1:0];
                        r_ddata <= in_data;
                        r_sum   <= r_sum + in_data;
                        r_cnt   <= r_cnt + 9'd1;
                    end
                end
                S_CSUM: begin
                    if (w_xfer) r_cnt <= {1'b0, r_len};
                end
                S_PAD: begin
                    if (r_cnt != c_LAST) r_cnt <= r_cnt + 9'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready   = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
        busy       = in_ready || (r_state == S_PAD);
        done       = (r_state == S_DONE);
        err        = (r_state == S_ERR);
        cpu_rst    = (r_state != S_DONE);
        imem_we    = r_dwe;
        imem_addr  = r_daddr;
        imem_wdata = r_ddata;
        if (r_state == S_PAD) begin
            imem_we    = 1'b1;
            imem_addr  = r_cnt[ADDR_W-1:0];
            imem_wdata = PAD_WORD;
        end
    end

endmodule
`default_nettype wire
